// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter: frames one client burst as header word + len data words into a TX buffer.
// Latency: grant one edge after request seen in IDLE; header next cycle, then one beat per cycle.
// Backpressure: full_i freezes state/counter/data and suppresses write_o and ack_o in that cycle.
module uart_tx_arbiter #(
   parameter int         N_CLIENTS = 4,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic [3:0]   req_i,
   input  logic [31:0]  len_i,
   input  logic [127:0] cdata_i,
   output logic [3:0]   ack_o,
   output logic [3:0]   grant_o,
   output logic         busy_o,
   input  logic         full_i,
   output logic         write_o,
   output logic [31:0]  data_o
);

   localparam int ID_W = $clog2(N_CLIENTS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HEADER = 2'd1,
      S_BURST  = 2'd2
   } state_t;

   state_t          r_state;
   logic [ID_W-1:0] r_id;
   logic [ID_W-1:0] r_rr_ptr;
   logic [7:0]      r_len;
   logic [7:0]      r_cnt;

   logic            w_busy;
   logic            w_write;
   logic            w_last;
   logic            w_found;
   logic [ID_W-1:0] w_pick;
   logic [ID_W-1:0] w_cand;
   logic [3:0]      w_owner_oh;

   assign w_busy     = (r_state != S_IDLE);
   assign w_write    = w_busy & ~full_i;
   assign w_last     = (r_cnt == (r_len - 8'd1));
   assign w_owner_oh = 4'b0001 << r_id;

   assign busy_o  = w_busy;
   assign write_o = w_write;
   assign grant_o = w_busy ? w_owner_oh : 4'b0000;
   assign ack_o   = ((r_state == S_BURST) && w_write) ? w_owner_oh : 4'b0000;

   // Pick the first requester at or after the round-robin pointer, wrapping upward
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      w_cand  = r_rr_ptr;
      for (int i = 0; i < N_CLIENTS; i++) begin
         w_cand = r_rr_ptr + ID_W'(i);
         if (!w_found && req_i[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   // Word presented to the buffer: header, owner's data slice, or zero when idle
   always_comb begin
      data_o = 32'h0;
      case (r_state)
         S_HEADER: data_o = {SYNC_BYTE, {(8 - ID_W){1'b0}}, r_id, 8'h00, r_len};
         S_BURST:  data_o = cdata_i[{r_id, 5'b00000} +: 32];
         default:  data_o = 32'h0;
      endcase
   end

   // Framing FSM: arbitrate in IDLE, send header, stream beats, advance pointer on exit
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         r_state  <= S_IDLE;
         r_id     <= '0;
         r_rr_ptr <= '0;
         r_len    <= 8'h00;
         r_cnt    <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_id    <= w_pick;
                  r_len   <= len_i[{w_pick, 3'b000} +: 8];
                  r_state <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (w_write) begin
                  r_cnt <= 8'h00;
                  if (r_len != 8'h00) begin
                     r_state <= S_BURST;
                  end else begin
                     r_state  <= S_IDLE;
                     r_rr_ptr <= r_id + 1'b1;
                  end
               end
            end
            S_BURST: begin
               if (w_write) begin
                  if (w_last) begin
                     r_state  <= S_IDLE;
                     r_rr_ptr <= r_id + 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
// Latency: model predicts every output each cycle; checks are taken on the falling edge.
// Backpressure: full_i is driven directly and randomly; model stalls word delivery on full.
module tb_uart_tx_arbiter;

   logic         clock_i = 1'b0;
   logic         reset_i = 1'b0;
   logic [3:0]   req_i   = 4'h0;
   logic [31:0]  len_i   = 32'h0;
   logic [127:0] cdata_i = 128'h0;
   logic         full_i  = 1'b0;
   logic [3:0]   ack_o;
   logic [3:0]   grant_o;
   logic         busy_o;
   logic         write_o;
   logic [31:0]  data_o;

   uart_tx_arbiter #(.N_CLIENTS(4), .SYNC_BYTE(8'hA5)) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .req_i   (req_i),
      .len_i   (len_i),
      .cdata_i (cdata_i),
      .ack_o   (ack_o),
      .grant_o (grant_o),
      .busy_o  (busy_o),
      .full_i  (full_i),
      .write_o (write_o),
      .data_o  (data_o)
   );

   always #5 clock_i = ~clock_i;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: a burst is just "owner + number of words still to deliver"
   bit m_busy    = 0;
   int m_owner   = 0;
   int m_rr      = 0;
   int m_len     = 0;
   int m_left    = 0;
   bit m_done    = 0;
   int m_done_id = 0;
   bit auto_drop = 1;

   // Logs of observed traffic
   logic [31:0] wr_log[$];
   int          wr_cyc[$];
   int          g_log[$];
   int          g_cyc[$];
   int          ack_cnt[4];
   int          busy_cyc;
   int          cyc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_logs();
      wr_log.delete();
      wr_cyc.delete();
      g_log.delete();
      g_cyc.delete();
      for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
      busy_cyc = 0;
      cyc      = 0;
   endtask

   // Compare DUT outputs with the model, log traffic, then advance the model over the next edge
   task automatic check_model();
      logic        e_busy, e_write, hdr;
      logic [3:0]  e_grant, e_ack;
      logic [31:0] e_data;
      e_busy  = m_busy;
      e_write = m_busy && !full_i;
      hdr     = m_busy && (m_left == m_len + 1);
      e_grant = m_busy ? 4'(1 << m_owner) : 4'h0;
      e_ack   = (e_write && !hdr) ? 4'(1 << m_owner) : 4'h0;
      e_data  = 32'h0;
      if (m_busy)
         e_data = hdr ? {8'hA5, 6'b0, 2'(m_owner), 8'h00, 8'(m_len)} : cdata_i[32*m_owner +: 32];
      check_val("busy",  32'(busy_o),  32'(e_busy));
      check_val("write", 32'(write_o), 32'(e_write));
      check_val("grant", 32'(grant_o), 32'(e_grant));
      check_val("ack",   32'(ack_o),   32'(e_ack));
      check_val("data",  data_o,       e_data);

      if (write_o === 1'b1) begin
         wr_log.push_back(data_o);
         wr_cyc.push_back(cyc);
      end
      for (int k = 0; k < 4; k++) if (ack_o[k] === 1'b1) ack_cnt[k]++;
      if (busy_o === 1'b1) busy_cyc++;

      if (!m_busy) begin
         if (req_i != 4'h0) begin
            for (int i = 0; i < 4; i++) begin
               if (!m_busy && req_i[(m_rr + i) % 4]) begin
                  m_owner = (m_rr + i) % 4;
                  m_busy  = 1;
               end
            end
            m_len  = int'(len_i[8*m_owner +: 8]);
            m_left = m_len + 1;
            g_log.push_back(m_owner);
            g_cyc.push_back(cyc);
         end
      end else if (e_write) begin
         m_left--;
         if (m_left == 0) begin
            m_busy    = 0;
            m_rr      = (m_owner + 1) % 4;
            m_done    = 1;
            m_done_id = m_owner;
         end
      end
      cyc++;
   endtask

   // One clock: check on the falling edge, return just after the next rising edge
   task automatic step();
      @(negedge clock_i);
      check_model();
      @(posedge clock_i);
      #1;
      if (auto_drop && m_done) req_i[m_done_id] = 1'b0;
      m_done = 0;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge
   task automatic do_reset();
      reset_i = 1'b1;
      #1;
      check_val("rst_write", 32'(write_o), 32'h0);
      check_val("rst_ack",   32'(ack_o),   32'h0);
      check_val("rst_grant", 32'(grant_o), 32'h0);
      check_val("rst_busy",  32'(busy_o),  32'h0);
      check_val("rst_data",  data_o,       32'h0);
      m_busy = 0;
      m_rr   = 0;
      m_left = 0;
      m_done = 0;
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
   endtask

   initial begin
      #2;
      do_reset();

      // Single client 1, len 3
      clear_logs();
      auto_drop = 1;
      full_i = 1'b0;
      len_i  = 32'h0000_0300;
      cdata_i[63:32] = 32'hDEAD_0001;
      req_i  = 4'b0010;
      for (int c = 0; c < 30 && !(ack_cnt[1] == 3 && !m_busy); c++) step();
      check_val("t1_done",  32'(ack_cnt[1] == 3 && !m_busy), 32'h1);
      check_val("t1_nwr",   32'(wr_log.size()), 32'd4);
      check_val("t1_hdr",   wr_log[0], 32'hA501_0003);
      check_val("t1_beat3", wr_log[3], 32'hDEAD_0001);
      check_val("t1_span",  32'(wr_cyc[3] - wr_cyc[0]), 32'd3);

      // All four continuously requesting, len 1 each
      do_reset();
      clear_logs();
      auto_drop = 0;
      len_i = 32'h0101_0101;
      cdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      req_i = 4'b1111;
      for (int c = 0; c < 60 && g_log.size() < 6; c++) step();
      check_val("t2_ngrant", 32'(g_log.size() >= 6), 32'h1);
      for (int i = 0; i < 5; i++) begin
         check_val("t2_order", 32'(g_log[i]), 32'(i % 4));
         check_val("t2_gap",   32'(g_cyc[i+1] - g_cyc[i]), 32'd3);
      end
      req_i = 4'b0000;
      for (int c = 0; c < 10 && m_busy; c++) step();

      // Client 2, len 4, five stall cycles after beat 1
      do_reset();
      clear_logs();
      auto_drop = 1;
      len_i = 32'h0004_0000;
      cdata_i[95:64] = 32'hCAFE_0002;
      req_i = 4'b0100;
      for (int c = 0; c < 20 && ack_cnt[2] < 1; c++) step();
      check_val("t3_beat1", 32'(ack_cnt[2]), 32'd1);
      full_i = 1'b1;
      for (int c = 0; c < 5; c++) step();
      full_i = 1'b0;
      for (int c = 0; c < 20 && m_busy; c++) step();
      check_val("t3_nwr",   32'(wr_log.size()), 32'd5);
      check_val("t3_nack",  32'(ack_cnt[2]), 32'd4);
      check_val("t3_stall", 32'(wr_cyc[2] - wr_cyc[1]), 32'd6);

      // Client 3, header-only burst
      do_reset();
      clear_logs();
      len_i = 32'h0000_0000;
      req_i = 4'b1000;
      for (int c = 0; c < 10 && !(g_log.size() > 0 && !m_busy); c++) step();
      step();
      check_val("t4_nwr",  32'(wr_log.size()), 32'd1);
      check_val("t4_hdr",  wr_log[0], 32'hA503_0000);
      check_val("t4_ack",  32'(ack_cnt[3]), 32'd0);
      check_val("t4_busy", 32'(busy_cyc), 32'd1);

      // Reset mid-burst, then a fresh header for client 0
      do_reset();
      clear_logs();
      len_i = 32'h0000_0008;
      cdata_i[31:0] = 32'hBEEF_0000;
      req_i = 4'b0001;
      for (int c = 0; c < 20 && ack_cnt[0] < 2; c++) step();
      check_val("t5_beats", 32'(ack_cnt[0]), 32'd2);
      do_reset();
      clear_logs();
      req_i = 4'b0001;
      for (int c = 0; c < 10 && wr_log.size() < 1; c++) step();
      check_val("t5_hdr", wr_log[0], 32'hA500_0008);
      for (int c = 0; c < 20 && m_busy; c++) step();

      // Client 0 drops req mid-burst while client 1 waits
      do_reset();
      clear_logs();
      len_i = 32'h0000_0203;
      req_i = 4'b0011;
      for (int c = 0; c < 20 && ack_cnt[0] < 1; c++) step();
      req_i[0] = 1'b0;
      for (int c = 0; c < 30 && !(g_log.size() >= 2 && !m_busy); c++) step();
      check_val("t6_ack0",   32'(ack_cnt[0]), 32'd3);
      check_val("t6_ack1",   32'(ack_cnt[1]), 32'd2);
      check_val("t6_first",  32'(g_log[0]), 32'd0);
      check_val("t6_second", 32'(g_log[1]), 32'd1);

      // Randomized traffic with random backpressure and occasional reset
      do_reset();
      clear_logs();
      req_i = 4'h0;
      for (int c = 0; c < 2000; c++) begin
         step();
         full_i = ($urandom_range(0, 99) < 30);
         for (int k = 0; k < 4; k++) begin
            if (m_busy && m_owner == k) begin
               len_i[8*k +: 8] = 8'($urandom);
               if ($urandom_range(0, 15) == 0) req_i[k] = 1'b0;
            end else if (!req_i[k] && $urandom_range(0, 7) == 0) begin
               len_i[8*k +: 8]    = 8'($urandom_range(0, 5));
               cdata_i[32*k +: 32] = $urandom;
               req_i[k]           = 1'b1;
            end
         end
         if ($urandom_range(0, 399) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_CLIENTS, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, header marker.
REQ-003 SHALL have port clock_i, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port reset_i, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port req_i, input, 4, per-client request for a burst.
REQ-006 SHALL have port len_i, input, 32, per-client 8-bit burst length; client k uses bits [8k+7:8k].
REQ-007 SHALL have port cdata_i, input, 128, per-client 32-bit data word; client k uses bits [32k+31:32k].
REQ-008 SHALL have port ack_o, output, 4, one-cycle pulse per accepted data beat of the granted client.
REQ-009 SHALL have port grant_o, output, 4, one-hot current owner; zero when idle.
REQ-010 SHALL have port busy_o, output, 1, high in HEADER or BURST.
REQ-011 SHALL have port full_i, input, 1, downstream transmit buffer full.
REQ-012 SHALL have port write_o, output, 1, write strobe into the transmit buffer.
REQ-013 SHALL have port data_o, output, 32, word written into the transmit buffer.

Function
REQ-014 SHALL implement states IDLE, HEADER, BURST, held in a registered state variable.
REQ-015 SHALL, in IDLE with any req_i bit set, grant the first requester at or after rr_ptr (modulo 4, ascending), latch its id and len, and enter HEADER at the next edge.
REQ-016 SHALL ignore req_i while in HEADER or BURST; grant changes only from IDLE.
REQ-017 SHALL drive write_o combinationally as busy_o AND NOT full_i; never assert write_o while full_i is high.
REQ-018 SHALL, in HEADER, drive data_o = {SYNC_BYTE, 6'b0, id[1:0], 8'h00, len[7:0]}; on a write, go to BURST if len != 0, else to IDLE.
REQ-019 SHALL, in BURST, drive data_o = cdata_i slice of the granted client and assert ack_o[id] in the same cycle as each write_o.
REQ-020 SHALL keep an 8-bit beat counter, cleared on entering BURST, incremented per write; on the write where counter == len-1, return to IDLE.
REQ-021 SHALL set rr_ptr = (id+1) mod 4 when returning to IDLE; a client with continuous request therefore cannot be granted twice while another requests.
REQ-022 SHALL stall in place (no state, counter or data change) on any cycle full_i is high.
REQ-023 SHALL treat len 0 as header-only burst: one write, no ack_o pulse.
REQ-024 SHALL continue a burst to completion if the granted client deasserts req_i mid-burst; clients hold req_i and cdata_i until their final ack.
REQ-025 SHALL spend at least one IDLE cycle between bursts (write_o low, grant_o zero).
REQ-026 SHALL drive data_o = 32'h0 and ack_o = 0 in IDLE.

Reset
REQ-027 SHALL, while reset_i high, force state IDLE, rr_ptr 0, counter 0, latched id/len 0, so write_o, ack_o, grant_o, busy_o, data_o are all 0 immediately (asynchronously).
REQ-028 SHALL abandon any in-progress burst on reset; no partial header or beat is re-sent after release.
REQ-029 SHALL resume arbitration on the first rising edge after reset_i falls.

Verification
REQ-030 Single client 1, len 3, full_i low -> writes 32'hA5010003 then 3 data words on consecutive cycles, ack_o=4'b0010 three times, back to IDLE.
REQ-031 All four requesting continuously, len 1 each, from reset -> grant order 0,1,2,3,0; each burst 2 writes; one idle cycle between.
REQ-032 Client 2, len 4, full_i high for 5 cycles after beat 1 -> no write_o/ack_o during stall, data_o holds beat 2, total 5 writes.
REQ-033 Client 3, len 0 -> single write 32'hA5030000, no ack_o, busy_o for exactly one cycle when not stalled.
REQ-034 reset_i asserted after beat 2 of a len 8 burst -> outputs zero same cycle; after release with req_i=4'b0001, next write is header 32'hA5000008 for client 0.
REQ-035 Client 0 drops req_i mid-burst while client 1 requests -> client 0 burst completes its len beats, then client 1 granted.
